// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter for the peripheral register bus: registers one access,
// issues a single-cycle slave strobe, then acks the winning master.
module periph_bus_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] ADDR_SPAN = 32'h0000_0020,
  parameter int unsigned LOCK_MAX  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic        m0_wr,
  input  logic        m1_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        s_rd,
  output logic        s_wr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic        gnt_id,
  output logic        busy
);

  localparam int unsigned    CW         = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0]  LOCK_MAX_C = CW'(LOCK_MAX);
  localparam logic [32:0]    WIN_END    = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_next;
  logic          last_owner;
  logic          lock_active;
  logic [CW-1:0] lock_cnt;
  logic          cur_wr;
  logic          cur_valid;

  logic          grant;
  logic          win;
  logic          keep_owner;
  logic [31:0]   win_addr;
  logic [31:0]   win_wdata;
  logic          win_wr;
  logic          win_lock;
  logic          win_valid;

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    win        = 1'b0;
    keep_owner = lock_active && (lock_cnt < LOCK_MAX_C);
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant      = 1'b1;
          state_next = ACCESS;
          if (m0_req && m1_req)
            win = keep_owner ? last_owner : ~last_owner;
          else
            win = m1_req;
        end
      end
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    win_addr  = win ? m1_addr  : m0_addr;
    win_wdata = win ? m1_wdata : m0_wdata;
    win_wr    = win ? m1_wr    : m0_wr;
    win_lock  = win ? m1_lock  : m0_lock;
    // 33-bit compare so a window touching the top of the address space cannot wrap
    win_valid = (win_addr[1:0] == 2'b00) &&
                ({1'b0, win_addr} >= {1'b0, BASE_ADDR}) &&
                ({1'b0, win_addr} < WIN_END);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      lock_active <= 1'b0;
      lock_cnt    <= '0;
      cur_wr      <= 1'b0;
      cur_valid   <= 1'b0;
      gnt_id      <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      state  <= state_next;
      m0_ack <= (state == ACCESS) && !gnt_id;
      m1_ack <= (state == ACCESS) && gnt_id;
      if (grant) begin
        s_addr      <= win_addr;
        s_wdata     <= win_wdata;
        cur_wr      <= win_wr;
        cur_valid   <= win_valid;
        lock_active <= win_lock;
        gnt_id      <= win;
        last_owner  <= win;
        if (win == last_owner)
          lock_cnt <= (lock_cnt < LOCK_MAX_C) ? lock_cnt + 1'b1 : lock_cnt;
        else
          lock_cnt <= CW'(1);
      end
      if (state == ACCESS) begin
        if (!gnt_id) begin
          m0_err   <= !cur_valid;
          m0_rdata <= (cur_valid && !cur_wr) ? s_rdata : '0;
        end else begin
          m1_err   <= !cur_valid;
          m1_rdata <= (cur_valid && !cur_wr) ? s_rdata : '0;
        end
      end
    end
  end

  // Strobes decode the live state so an asynchronous reset removes them at once
  assign s_rd = (state == ACCESS) && cur_valid && !cur_wr;
  assign s_wr = (state == ACCESS) && cur_valid && cur_wr;
  assign busy = (state != IDLE);

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
Arbitrates between two masters (m0 = CPU data port, m1 = secondary master such as a UART/DMA engine) for the single memory-mapped peripheral bus: timer, LED, digit and systick registers. Each access is registered, then issued to the slave as a one-cycle rd or wr strobe. The winning master gets a one-cycle ack carrying read data or an error flag. Supports round-robin fairness, bounded bus locking for read-modify-write sequences, and address-range and alignment checking.

Parameters:
BASE_ADDR, 32'h40000000, first byte address of the peripheral window
ADDR_SPAN, 32'h20, window size in bytes; valid word offsets are 0 to ADDR_SPAN-4
LOCK_MAX, 4, maximum consecutive grants to one master while the other master is requesting

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
m0_req, m1_req  in  1  transaction request; held with the transaction fields until ack
m0_lock, m1_lock  in  1  request to keep ownership for the next transaction
m0_wr, m1_wr  in  1  1 = write, 0 = read
m0_addr, m1_addr  in  32  byte address
m0_wdata, m1_wdata  in  32  write data
m0_ack, m1_ack  out  1  one-cycle completion pulse
m0_err, m1_err  out  1  valid with ack; 1 = address out of range or misaligned
m0_rdata, m1_rdata  out  32  read data; valid with ack, held until that master's next ack
s_rd, s_wr  out  1  one-cycle slave strobes
s_addr  out  32  registered slave address
s_wdata  out  32  registered slave write data
s_rdata  in  32  combinational slave read data
gnt_id  out  1  current or last owner
busy  out  1  1 in ACCESS and DONE

Behaviour:
- Reset (reset low, asynchronous) forces all of the following:
  - state = IDLE; all ack, err, s_rd and s_wr = 0.
  - s_addr, s_wdata, m0_rdata and m1_rdata = 0.
  - gnt_id = 0, last_owner = 1 (so m0 wins the first tie), lock_cnt = 0, lock_active = 0, busy = 0.
- FSM states:
  - IDLE: if any req is high, choose a winner; go to ACCESS.
  - ACCESS: drive the slave; go to DONE.
  - DONE: ack the winner; go to IDLE. No back-to-back issue.
- Arbitration in IDLE:
  - Only one req high: that master wins.
  - Both high: last_owner wins if lock_active=1 and lock_cnt < LOCK_MAX; otherwise the master other than last_owner wins.
- On grant:
  - Latch the winner's addr, wdata, wr and lock; lock_active <= winner's lock; gnt_id and last_owner <= winner.
  - lock_cnt <= lock_cnt+1 (saturating at LOCK_MAX) if winner == previous last_owner, else lock_cnt <= 1.
- Decode at grant: valid = (addr[1:0] == 0) and BASE_ADDR <= addr < BASE_ADDR+ADDR_SPAN (32-bit unsigned compare, no wrap).
- ACCESS (exactly one cycle):
  - s_rd = valid & !wr; s_wr = valid & wr.
  - Invalid access: both strobes stay 0.
  - At the end edge, the slave commits the write; a valid read captures s_rdata into the winner's rdata.
  - A write or invalid access loads the winner's rdata with 0.
- DONE (one cycle):
  - Winner's ack = 1, err = !valid.
  - Other master's ack, err and rdata are unchanged (ack 0).
- Latency: req sampled high at edge k gives strobes in cycle k+1 and ack in cycle k+2. A master is served at most once per 3 cycles.
- Master protocol: req and fields stay stable until ack. The master drops req, or presents a new transaction, at the edge that ends its ack cycle.
  - The arbiter ignores field changes after grant.
  - A req dropped during ACCESS or DONE does not abort the transaction.
- Reset low mid-ACCESS: strobes drop immediately; no ack is ever issued for that transaction.
- busy = (state != IDLE); s_addr and s_wdata hold their last value in IDLE.

Test Plan:
1. m0 reads 0x40000008, slave returns 0x00000005 -> cycle 1: s_rd=1 for exactly one cycle, s_addr=0x40000008; cycle 2: m0_ack=1, m0_err=0, m0_rdata=0x5; m1_ack stays 0.
2. m0 writes 0x4000000C with wdata 0x000000A5 -> one-cycle s_wr, s_wdata=0xA5, s_rd=0; m0_ack with m0_rdata=0.
3. Both masters request continuously after reset, lock=0 -> grants alternate m0, m1, m0, m1; one ack every 3 cycles; gnt_id toggles.
4. m1_lock=1 held, both requesting, LOCK_MAX=4, m1 owns first -> m1 receives 4 consecutive acks, then m0 is granted.
5. Invalid accesses: m1 reads 0x40000020, then 0x40000006 -> s_rd and s_wr never assert; m1_ack=1 with m1_err=1 and m1_rdata=0 each time.
6. reset pulsed low during the ACCESS cycle of an m0 write -> s_wr falls asynchronously; no m0_ack after release. A following simultaneous m0/m1 request grants m0 first.
